// File: rtl/p2s_pkg.sv
// Shared types and constants for the parallel-to-serial converter.
// Bit order is selected at build time with P2S_LSB_FIRST_EN (see parallel_to_serial_4b).
package p2s_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_e;

    localparam int P2S_DEFAULT_WIDTH = 4;

    // Counter width needed to hold WIDTH-1 (the bits left after the first).
    function automatic int p2s_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/p2s_bit_counter.sv
// Loadable down-counter tracking how many bits remain after the one on the line.
module p2s_bit_counter
    import p2s_pkg::*;
#(
    parameter int WIDTH = P2S_DEFAULT_WIDTH,
    localparam int CW   = p2s_cnt_w(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_en,
    input  logic dec_en,
    output logic zero
);

    logic [CW-1:0] count_q, count_d;

    // Load has priority over decrement so a reload restarts the word cleanly.
    always_comb begin
        count_d = count_q;
        if (load_en)
            count_d = CW'(WIDTH - 1);
        else if (dec_en)
            count_d = count_q - 1'b1;
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/parallel_to_serial_4b.sv
// Parallel-in/serial-out converter: captures a word on load, emits one bit per clock.
// Define P2S_LSB_FIRST_EN for LSB-first output; default build is MSB first.
module parallel_to_serial_4b
    import p2s_pkg::*;
#(
    parameter int WIDTH = P2S_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] p_data,
    output logic             s_data,
    output logic             valid,
    output logic             empty
);

    localparam int SW = WIDTH - 1;

    p2s_state_e    state_q, state_d;
    logic [SW-1:0] shreg_q, shreg_d;
    logic          s_data_q, s_data_d;
    logic          valid_q, valid_d;
    logic          empty_q, empty_d;

    logic          first_bit;
    logic [SW-1:0] rest_bits;
    logic          next_bit;
    logic [SW-1:0] shreg_shifted;
    logic          cnt_zero;
    logic          cnt_dec;

`ifdef P2S_LSB_FIRST_EN
    assign first_bit     = p_data[0];
    assign rest_bits     = p_data[WIDTH-1:1];
    assign next_bit      = shreg_q[0];
    assign shreg_shifted = shreg_q >> 1;
`else
    assign first_bit     = p_data[WIDTH-1];
    assign rest_bits     = p_data[SW-1:0];
    assign next_bit      = shreg_q[SW-1];
    assign shreg_shifted = shreg_q << 1;
`endif

    // Decrement only while bits remain and no reload is restarting the word.
    assign cnt_dec = (state_q == SHIFT) && !load && !cnt_zero;

    p2s_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load_en (load),
        .dec_en  (cnt_dec),
        .zero    (cnt_zero)
    );

    // Next-state and next-output logic; load wins in any state.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        s_data_d = 1'b0;
        valid_d  = 1'b0;
        empty_d  = 1'b1;
        if (load) begin
            state_d  = SHIFT;
            shreg_d  = rest_bits;
            s_data_d = first_bit;
            valid_d  = 1'b1;
            empty_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            if (!cnt_zero) begin
                shreg_d  = shreg_shifted;
                s_data_d = next_bit;
                valid_d  = 1'b1;
                empty_d  = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // FSM, shift register and registered outputs; reset overrides load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            s_data_q <= 1'b0;
            valid_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            s_data_q <= s_data_d;
            valid_q  <= valid_d;
            empty_q  <= empty_d;
        end
    end

    assign s_data = s_data_q;
    assign valid  = valid_q;
    assign empty  = empty_q;

endmodule

// File: tb/tb_parallel_to_serial_4b.sv
// Scoreboard bench for parallel_to_serial_4b: stimulus pushes expected bits and
// valid run lengths; a negedge monitor pops and compares as the DUT emits them.
module tb_parallel_to_serial_4b;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] p_data;
    logic       s_data;
    logic       valid;
    logic       empty;

    int   errors = 0;
    int   checks = 0;
    logic exp_bits[$];
    int   exp_runs[$];
    int   run_len = 0;

    parallel_to_serial_4b #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .p_data (p_data),
        .s_data (s_data),
        .valid  (valid),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-written expected bit sequence, listed first-emitted first.
    task automatic push_bits(input logic [7:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) exp_bits.push_back(seq[i]);
    endtask

    // Strobe load for one edge; returns #1 after the capturing edge.
    task automatic send(input logic [3:0] w);
        load   = 1'b1;
        p_data = w;
        @(posedge clk); #1;
        load   = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, "_valid"}, valid, 0);
        check({name, "_empty"}, empty, 1);
        check({name, "_sdata"}, s_data, 0);
    endtask

    // Monitor: per-cycle invariants, bit scoreboard, valid run-length scoreboard.
    always @(negedge clk) begin
        check("empty_is_not_valid", empty, !valid);
        if (!valid) check("sdata_zero_when_idle", s_data, 0);
        if (valid) begin
            run_len++;
            if (exp_bits.size() == 0) begin
                check("unexpected_bit", 1, 0);
            end else begin
                check("s_data_bit", s_data, exp_bits.pop_front());
            end
        end else if (run_len > 0) begin
            if (exp_runs.size() == 0) check("unexpected_run", run_len, 0);
            else check("valid_run_len", run_len, exp_runs.pop_front());
            run_len = 0;
        end
    end

    initial begin
        rst    = 1'b1;
        load   = 1'b1;
        p_data = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst  = 1'b0;
        load = 1'b0;
        wait_edges(1);

`ifdef P2S_LSB_FIRST_EN
        // LSB-first build: 1000 -> 0,0,0,1
        push_bits(8'b0001, 4); exp_runs.push_back(4);
        send(4'b1000);
        wait_edges(4);
        check_idle("lsb_1000_end");

        // 1010 -> 0,1,0,1
        push_bits(8'b0101, 4); exp_runs.push_back(4);
        send(4'b1010);
        wait_edges(4);
        check_idle("w1010_end");

        // Back-to-back 1100 then 0011 -> 0,0,1,1,1,1,0,0
        push_bits(8'b00111100, 8); exp_runs.push_back(8);
        send(4'b1100);
        wait_edges(3);
        send(4'b0011);
        wait_edges(4);
        check_idle("b2b_end");

        // Abort 1010 after two bits -> 0,1; then 0110 -> 0,1,1,0
        push_bits(8'b01, 2); exp_runs.push_back(2);
        send(4'b1010);
        wait_edges(1);
        rst = 1'b1;
        wait_edges(1);
        rst = 1'b0;
        check_idle("abort");
        push_bits(8'b0110, 4); exp_runs.push_back(4);
        send(4'b0110);
        wait_edges(4);
        check_idle("after_abort_end");
`else
        // 1010 -> 1,0,1,0
        push_bits(8'b1010, 4); exp_runs.push_back(4);
        send(4'b1010);
        wait_edges(4);
        check_idle("w1010_end");

        // 1111 then 0101 after idle
        push_bits(8'b1111, 4); exp_runs.push_back(4);
        send(4'b1111);
        wait_edges(4);
        check_idle("w1111_end");
        wait_edges(1);
        push_bits(8'b0101, 4); exp_runs.push_back(4);
        send(4'b0101);
        wait_edges(4);
        check_idle("w0101_end");

        // Back-to-back 1100 then 0011 on its last bit -> 1,1,0,0,0,0,1,1
        push_bits(8'b11000011, 8); exp_runs.push_back(8);
        send(4'b1100);
        wait_edges(3);
        send(4'b0011);
        wait_edges(4);
        check_idle("b2b_end");

        // Abort 1010 after two bits -> 1,0; then 0110 -> 0,1,1,0
        push_bits(8'b10, 2); exp_runs.push_back(2);
        send(4'b1010);
        wait_edges(1);
        rst = 1'b1;
        wait_edges(1);
        rst = 1'b0;
        check_idle("abort");
        push_bits(8'b0110, 4); exp_runs.push_back(4);
        send(4'b0110);
        wait_edges(4);
        check_idle("after_abort_end");
`endif

        wait_edges(3);
        check("bits_left_in_queue", exp_bits.size(), 0);
        check("runs_left_in_queue", exp_runs.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on simulation time.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/parallel_to_serial_4b.md
# parallel_to_serial_4b

Parallel-in/serial-out converter. Captures a WIDTH-bit word on a one-cycle `load` strobe. Shifts the word out one bit per clock on `s_data`, with `valid` marking each bit and `empty` flagging an idle converter. It sits at the transmit edge of a datapath, between a word-oriented producer and a single-wire serial consumer.

## Interface
Parameters:
- `WIDTH`, default 4: word width in bits; legal range is 2 or more.

Ports:
- `clk`, input, 1: sole clock; everything is on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `load`, input, 1: capture strobe; `p_data` is sampled on an edge where `load`=1.
- `p_data`, input, WIDTH: parallel word to transmit.
- `s_data`, output, 1: registered serial bit.
- `valid`, output, 1: registered; `s_data` carries a payload bit this cycle.
- `empty`, output, 1: registered; nothing pending or being output, always equal to ~`valid`.

## Operation
- The FSM has two states, IDLE and SHIFT.
- Reset has priority over `load`. On reset: state=IDLE, `s_data`=0, `valid`=0, `empty`=1, shift register=0, counter=0.
- IDLE with `load`=1 (edge):
  - `s_data` ← first bit.
  - The remaining WIDTH-1 bits go to the shift register.
  - counter ← WIDTH-1, `valid`=1, `empty`=0, go to SHIFT.
- SHIFT with counter>0 and `load`=0: output the next bit, decrement the counter, and hold `valid`=1.
- SHIFT with counter=0 (last bit on the line) and `load`=0:
  - Go to IDLE.
  - `s_data`=0, `valid`=0, `empty`=1.
- `load`=1 in any state restarts the sequence with the new `p_data`. Any remaining bits of the current word are discarded.
- `load` on the last-bit cycle gives seamless back-to-back words, with no idle gap.
- `load` held high reloads every cycle, so only the first bit of each word is ever emitted. This is legal but not useful.
- Default bit order is MSB first (`p_data[WIDTH-1]` first).
- `s_data` is forced to 0 whenever `valid`=0.

## Timing
- Latency from the `load` edge is 0 cycles. The first bit is visible immediately after the capturing edge.
- `valid` is high for exactly WIDTH consecutive cycles per load without interruption.
- `empty` rises on the same edge that `valid` falls.
- A reset asserted mid-word aborts the word at that edge. Outputs take their reset values one edge later than the asserting edge is sampled; no partial bits follow.
- There is no backpressure; the consumer must accept one bit per cycle while `valid`=1.

## Configuration
- `P2S_LSB_FIRST_EN`:
  - When defined, bits are emitted LSB first (`p_data[0]` first) and the shift register shifts right.
  - When undefined, bits are emitted MSB first and the shift register shifts left.
  - Timing, `valid` and `empty` behaviour are identical in both builds.

## Structure
- Shared package `p2s_pkg` holds:
  - the state typedef (IDLE, SHIFT);
  - the default width constant `P2S_DEFAULT_WIDTH`=4;
  - a counter-width helper function, `$clog2(WIDTH)`.
- One sub-module is natural: `p2s_bit_counter`, a loadable down-counter with a zero flag. The top level holds the FSM, the shift register and the output registers.

## Test plan
- Reset: assert `rst` for one cycle. Expect `s_data`=0, `valid`=0, `empty`=1, with `load`=1 during reset ignored.
- Load 4'b1010 (MSB build). Expect `s_data`=1,0,1,0 on the four cycles after the edge with `valid`=1 and `empty`=0. On the fifth cycle, `valid`=0 and `empty`=1.
- Load 4'b1111, then 4'b0101 after idle. Expect 1,1,1,1 then 0,1,0,1, with `valid` low and `empty` high between the words.
- Back-to-back: load 4'b1100, then load 4'b0011 on its fourth bit cycle. Expect 1,1,0,0,0,0,1,1 with `valid` continuously high for 8 cycles.
- Abort: load 4'b1010, then assert `rst` after 2 bits. Expect 1,0 followed by reset values with no further bits; a new load 4'b0110 then produces 0,1,1,0.
- `P2S_LSB_FIRST_EN` build: load 4'b1000. Expect `s_data`=0,0,0,1 with identical `valid`/`empty` timing.
